maze_gen: RTL
=============

# maze_gen

- Generates the 40×30 wall bitmap that the VGA drawing stage rasterises.
- Uses the binary-tree algorithm driven by a 16-bit LFSR, at one cell per clock.
- Sits directly upstream of the drawing stage: `o_MazeMap` and `o_MazeLevel` connect straight to its map and level inputs.
- The game controller asserts `i_Start` on each new level.

## Interface
Parameters:
- `SEED_DEFAULT`, 16'hACE1, LFSR value used at reset and whenever `i_Seed` is 0.

Ports:
- `i_Clk`  in  1  system clock.
- `i_Rst`  in  1  reset, asynchronous, active-low.
- `i_Start`  in  1  generation request; sampled only in IDLE.
- `i_MazeLevel`  in  2  size select:
  - 00 Easy, 16×12.
  - 01 Normal, 32×24.
  - 10 Hard, 40×30.
  - 11 treated as Hard.
- `i_Seed`  in  16  LFSR seed, latched on start.
- `o_MazeMap`  out  1200  wall bitmap; bit index row*40+col; 1 = wall, 0 = floor or outside the active area.
- `o_MazeLevel`  out  2  level latched on start (11 stored as 10).
- `o_Busy`  out  1  high in CLEAR and CARVE.
- `o_Done`  out  1  one-cycle pulse when the map is complete.
- `o_GoalRow`  out  5  goal cell row.
- `o_GoalCol`  out  6  goal cell column.

## Operation
- Active area per level is W×H: Easy 16×12, Normal 32×24, Hard 40×30.
- Cells sit at odd (r,c), with r ≤ Rl and c ≤ Cl:
  - Easy: Rl=9, Cl=13, 35 cells.
  - Normal: Rl=21, Cl=29, 165 cells.
  - Hard: Rl=27, Cl=37, 266 cells.
- Start cell is (1,1); goal cell is (Rl,Cl), presented on `o_GoalRow`/`o_GoalCol`.
- FSM states and transitions:
  - IDLE: on `i_Start`, latch the level (11 stored as 10) and load the LFSR with `i_Seed` (`SEED_DEFAULT` if the seed is 0), then go to CLEAR.
  - CLEAR: load the map with 1 for every bit with row<H and col<W, 0 elsewhere. Set the cell pointer to (1,1). Go to CARVE.
  - CARVE: each cycle, clear the current cell bit, then clear the connecting wall bit chosen as follows:
    - r=1 and c=Cl: clear no wall.
    - r=1, other columns: clear east (r,c+1).
    - c=Cl, other rows: clear north (r-1,c).
    - Otherwise, using `lfsr[0]`: 1 clears north, 0 clears east.
  - CARVE, after the carve: advance the LFSR one step. Step the pointer c+=2; when c passes Cl, set c=1 and r+=2. After cell (Rl,Cl), go to DONE.
  - DONE: `o_Done`=1 for one cycle, then return to IDLE.
- LFSR is Fibonacci, taps 16,14,13,11; it shifts left and the feedback enters bit 0.
- The result is a perfect maze: cells carved = N, walls carved = N−1.
- `i_Start` in any state other than IDLE is ignored.
- Changes on `i_MazeLevel` or `i_Seed` outside the start cycle are ignored.
- The map updates in place during generation. The consumer must ignore the map while `o_Busy`=1.

## Timing
- Reset values:
  - State IDLE.
  - `o_MazeMap`=0, `o_MazeLevel`=0.
  - `o_Busy`=0, `o_Done`=0.
  - `o_GoalRow`=0, `o_GoalCol`=0.
  - LFSR=`SEED_DEFAULT`.
- Start sampled at edge 0:
  - `o_Busy` goes high after edge 0.
  - The mask is loaded at edge 1.
  - Carves occur at edges 2..N+1.
  - `o_Done` is high in the cycle after edge N+1, with `o_Busy` low at the same time.
- Start-to-done is N+2 cycles: Easy 37, Normal 167, Hard 268.
- Goal and level outputs are valid from edge 1 and hold until the next start.
- `i_Start` held high through DONE re-triggers in the first IDLE cycle after DONE.
- Reset mid-operation: immediate return to all reset values. A partial map is never retained.

## Structure
- Shared package `maze_pkg` holds:
  - Level encodings EASY/NORMAL/HARD.
  - `MAP_W`=40, `MAP_H`=30.
  - Per-level W, H, Rl, Cl constants.
  - The bit-index function row*40+col.
- One sub-module, `lfsr16`, with ports: load, seed, step enable, 16-bit state.

## Test plan
- Reset: assert `i_Rst`=0 with `i_Start` toggling -> all outputs 0; no Done.
- Easy, seed 16'h1234: Done exactly 37 cycles after the start edge. Map has 123 ones, all within row<12, col<16. Bits (1,1) and (9,13) are 0. Goal is (9,13).
- Normal, seed 0: LFSR uses 16'hACE1. Done after 167 cycles. 439 ones. Every bit with col≥32 or row≥24 is 0. BFS from (1,1) reaches all 165 cells.
- Hard, level 11: `o_MazeLevel`=10. Done after 268 cycles. 669 ones. Row 0, row 29, col 0 and col 39 are all 1.
- Start pulses during CARVE, plus a level change mid-run -> ignored; output is identical to an undisturbed run with the same seed.
- Reset asserted at cycle 50 of a Hard run -> map=0 and Busy=0 immediately. A subsequent Easy start completes correctly.

Source files
------------

// File: rtl/maze_gen_pkg.sv
// Shared constants, encodings and helpers for the maze generator.
package maze_pkg;

    // Level select encodings; 2'b11 is folded onto HARD on entry.
    typedef enum logic [1:0] {
        EASY   = 2'b00,
        NORMAL = 2'b01,
        HARD   = 2'b10
    } level_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_CARVE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int unsigned MAP_W    = 40;
    localparam int unsigned MAP_H    = 30;
    localparam int unsigned MAP_BITS = MAP_W * MAP_H;

    // Active area per level
    localparam logic [5:0] EASY_W   = 6'd16;
    localparam logic [4:0] EASY_H   = 5'd12;
    localparam logic [5:0] NORMAL_W = 6'd32;
    localparam logic [4:0] NORMAL_H = 5'd24;
    localparam logic [5:0] HARD_W   = 6'd40;
    localparam logic [4:0] HARD_H   = 5'd30;

    // Last cell row/column per level (goal cell)
    localparam logic [4:0] EASY_RL   = 5'd9;
    localparam logic [5:0] EASY_CL   = 6'd13;
    localparam logic [4:0] NORMAL_RL = 5'd21;
    localparam logic [5:0] NORMAL_CL = 6'd29;
    localparam logic [4:0] HARD_RL   = 5'd27;
    localparam logic [5:0] HARD_CL   = 6'd37;

    function automatic level_e level_norm(input logic [1:0] raw);
        return (raw == 2'b11) ? HARD : level_e'(raw);
    endfunction

    function automatic logic [5:0] level_w(input level_e lv);
        case (lv)
            EASY:    return EASY_W;
            NORMAL:  return NORMAL_W;
            default: return HARD_W;
        endcase
    endfunction

    function automatic logic [4:0] level_h(input level_e lv);
        case (lv)
            EASY:    return EASY_H;
            NORMAL:  return NORMAL_H;
            default: return HARD_H;
        endcase
    endfunction

    function automatic logic [4:0] level_rl(input level_e lv);
        case (lv)
            EASY:    return EASY_RL;
            NORMAL:  return NORMAL_RL;
            default: return HARD_RL;
        endcase
    endfunction

    function automatic logic [5:0] level_cl(input level_e lv);
        case (lv)
            EASY:    return EASY_CL;
            NORMAL:  return NORMAL_CL;
            default: return HARD_CL;
        endcase
    endfunction

    // Flat bitmap index: row*40+col
    function automatic logic [10:0] bit_idx(input logic [4:0] row, input logic [5:0] col);
        return 11'(row) * 11'(MAP_W) + 11'(col);
    endfunction

endpackage

// File: rtl/maze_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; shifts left, feedback into bit 0.
module lfsr16 #(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Load,
    input  logic [15:0] i_Seed,
    input  logic        i_Step,
    output logic [15:0] o_State
);

    logic feedback;

    assign feedback = o_State[15] ^ o_State[13] ^ o_State[12] ^ o_State[10];

    // Load has priority over stepping
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_State <= RESET_VAL;
        end else if (i_Load) begin
            o_State <= i_Seed;
        end else if (i_Step) begin
            o_State <= {o_State[14:0], feedback};
        end
    end

endmodule

// File: rtl/maze_gen.sv
// Binary-tree maze generator: fills the wall bitmap for the selected level,
// then carves one cell per clock using an LFSR to choose north or east.
module maze_gen
    import maze_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic [1:0]          i_MazeLevel,
    input  logic [15:0]         i_Seed,
    output logic [MAP_BITS-1:0] o_MazeMap,
    output logic [1:0]          o_MazeLevel,
    output logic                o_Busy,
    output logic                o_Done,
    output logic [4:0]          o_GoalRow,
    output logic [5:0]          o_GoalCol
);

    state_e                state_q;
    state_e                state_d;
    level_e                level_q;
    logic [4:0]            row_q;
    logic [5:0]            col_q;
    logic [MAP_BITS-1:0]   mask;
    logic [15:0]           lfsr;
    logic                  start_ok;
    logic [15:0]           seed_eff;
    logic [4:0]            rl_cur;
    logic [5:0]            cl_cur;
    logic                  at_last;
    logic                  wall_en;
    logic [10:0]           cell_idx;
    logic [10:0]           wall_idx;

    assign start_ok = (state_q == ST_IDLE) && i_Start;
    assign seed_eff = (i_Seed == 16'h0000) ? SEED_DEFAULT : i_Seed;
    assign rl_cur   = level_rl(level_q);
    assign cl_cur   = level_cl(level_q);
    assign at_last  = (row_q == rl_cur) && (col_q == cl_cur);

    assign o_MazeLevel = level_q;

    lfsr16 #(
        .RESET_VAL(SEED_DEFAULT)
    ) u_lfsr (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Load (start_ok),
        .i_Seed (seed_eff),
        .i_Step (state_q == ST_CARVE),
        .o_State(lfsr)
    );

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        state_d = state_q;
        o_Busy  = 1'b0;
        o_Done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_Busy  = 1'b1;
                state_d = ST_CARVE;
            end
            ST_CARVE: begin
                o_Busy = 1'b1;
                if (at_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_Done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Initial wall mask: every bit inside the active W x H area is a wall
    always_comb begin
        mask = '0;
        for (int unsigned r = 0; r < MAP_H; r++) begin
            for (int unsigned c = 0; c < MAP_W; c++) begin
                mask[11'(r * MAP_W + c)] = (r < 32'(level_h(level_q))) &&
                                           (c < 32'(level_w(level_q)));
            end
        end
    end

    // Carve targets: current cell plus the connecting wall (north or east)
    always_comb begin
        cell_idx = bit_idx(row_q, col_q);
        wall_idx = bit_idx(row_q, col_q + 6'd1);
        wall_en  = 1'b1;
        if (row_q == 5'd1) begin
            wall_en = (col_q != cl_cur);
        end else if (col_q == cl_cur) begin
            wall_idx = bit_idx(row_q - 5'd1, col_q);
        end else if (lfsr[0]) begin
            wall_idx = bit_idx(row_q - 5'd1, col_q);
        end
    end

    // Level/goal latch, cell pointer and bitmap updates
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            level_q   <= EASY;
            o_GoalRow <= '0;
            o_GoalCol <= '0;
            row_q     <= '0;
            col_q     <= '0;
            o_MazeMap <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        level_q   <= level_norm(i_MazeLevel);
                        o_GoalRow <= level_rl(level_norm(i_MazeLevel));
                        o_GoalCol <= level_cl(level_norm(i_MazeLevel));
                    end
                end
                ST_CLEAR: begin
                    o_MazeMap <= mask;
                    row_q     <= 5'd1;
                    col_q     <= 6'd1;
                end
                ST_CARVE: begin
                    o_MazeMap[cell_idx] <= 1'b0;
                    if (wall_en) begin
                        o_MazeMap[wall_idx] <= 1'b0;
                    end
                    if (col_q == cl_cur) begin
                        col_q <= 6'd1;
                        row_q <= row_q + 5'd2;
                    end else begin
                        col_q <= col_q + 6'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
